// File: rtl/ahb_keypad.sv
// ============================================================================
// ahb_keypad : AHB-Lite slave scanning a 4x4 active-low keypad, debouncing
//              whole frames and queueing key codes in a 4-entry FIFO.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ahb_keypad #(
  parameter int SCAN_DIV = 13,
  parameter int DEBOUNCE = 3
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [3:0]  col,
  input  logic [3:0]  row,
  output logic        irq
);

  localparam int            SW         = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);

  logic [1:0]          addr_q;
  logic                write_q, read_q;
  logic                scan_en_q, irq_en_q, ovf_q, irq_q;
  logic [3:0]          row_meta_q, row_sync_q;
  logic [SCAN_DIV-1:0] presc_q;
  logic [1:0]          cidx_q;
  logic [15:0]         frame_q, prev_q, acc_q, acc_old_q;
  logic [SW-1:0]       stable_q, stable_d;
  logic [3:0]          fifo_q [4];
  logic [1:0]          wptr_q, rptr_q;
  logic [2:0]          count_q;

  logic                tick, frame_done;
  logic [15:0]         new_frame, newly;
  logic                push, push_ok, pop, ovf_clr;
  logic [3:0]          push_code;
  logic                w_unused;

  assign w_unused = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:4], HWDATA[2]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= 2'd0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
    end else if (HREADY) begin
      addr_q  <= HADDR[3:2];
      write_q <= HSEL & HWRITE & HTRANS[1];
      read_q  <= HSEL & ~HWRITE & HTRANS[1];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      scan_en_q <= 1'b0;
      irq_en_q  <= 1'b0;
    end else if (write_q && addr_q == 2'd2) begin
      scan_en_q <= HWDATA[0];
      irq_en_q  <= HWDATA[1];
    end
  end

  // Rows are asynchronous to HCLK; nothing downstream sees them unsynchronised.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      row_meta_q <= 4'd0;
      row_sync_q <= 4'd0;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
    end
  end

  assign tick       = scan_en_q & (presc_q == '1);
  assign frame_done = tick & (cidx_q == 2'd3);
  assign new_frame  = {~row_sync_q, frame_q[11:0]};
  assign newly      = acc_q & ~acc_old_q;

  always_comb begin
    stable_d = SW'(1);
    if (new_frame == prev_q)
      stable_d = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      presc_q   <= '0;
      cidx_q    <= 2'd0;
      frame_q   <= 16'd0;
      prev_q    <= 16'd0;
      stable_q  <= '0;
      acc_q     <= 16'd0;
      acc_old_q <= 16'd0;
    end else begin
      acc_old_q <= acc_q;
      if (!scan_en_q) begin
        presc_q  <= '0;
        cidx_q   <= 2'd0;
        frame_q  <= 16'd0;
        prev_q   <= 16'd0;
        stable_q <= '0;
        acc_q    <= 16'd0;
      end else begin
        presc_q <= presc_q + 1'b1;
        if (tick) begin
          frame_q[{cidx_q, 2'b00} +: 4] <= ~row_sync_q;
          cidx_q <= cidx_q + 1'b1;
        end
        if (frame_done) begin
          prev_q   <= new_frame;
          stable_q <= stable_d;
          if (stable_d == STABLE_MAX)
            acc_q <= new_frame;
        end
      end
    end
  end

  // Only the lowest-index newly pressed key of an accepted frame is queued.
  always_comb begin
    push_code = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (newly[i]) push_code = 4'(i);
  end

  assign push    = |newly;
  assign pop     = read_q & (addr_q == 2'd0) & (count_q != 3'd0);
  assign push_ok = push & ((count_q != 3'd4) | pop);
  assign ovf_clr = write_q & (addr_q == 2'd1) & HWDATA[3];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= 4'd0;
      wptr_q  <= 2'd0;
      rptr_q  <= 2'd0;
      count_q <= 3'd0;
      ovf_q   <= 1'b0;
    end else begin
      if (pop)
        rptr_q <= rptr_q + 1'b1;
      if (push_ok) begin
        fifo_q[wptr_q] <= push_code;
        wptr_q         <= wptr_q + 1'b1;
      end
      if (push_ok && !pop)
        count_q <= count_q + 1'b1;
      else if (pop && !push_ok)
        count_q <= count_q - 1'b1;
      if (push && !push_ok)
        ovf_q <= 1'b1;
      else if (ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) irq_q <= 1'b0;
    else          irq_q <= irq_en_q & (count_q != 3'd0);
  end

  always_comb begin
    HRDATA = 32'd0;
    case (addr_q)
      2'd0:    if (count_q != 3'd0) HRDATA = {23'd0, 1'b1, 4'd0, fifo_q[rptr_q]};
      2'd1:    HRDATA = {27'd0, |acc_q, ovf_q, count_q};
      2'd2:    HRDATA = {30'd0, irq_en_q, scan_en_q};
      default: HRDATA = 32'd0;
    endcase
  end

  assign col       = scan_en_q ? ~(4'b0001 << cidx_q) : 4'hF;
  assign HREADYOUT = 1'b1;
  assign irq       = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb_keypad.sv
// ============================================================================
// tb_ahb_keypad : self-checking bench for ahb_keypad with a keypad matrix model
//                 and a queue-based key FIFO reference.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ahb_keypad;

  localparam int FRAME = 16;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL, HREADY, HWRITE;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HREADYOUT;
  logic [3:0]  col, row;
  logic        irq;
  logic [15:0] keys;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  bit exp_ovf = 0;

  ahb_keypad #(.SCAN_DIV(2), .DEBOUNCE(3)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .col(col), .row(row), .irq(irq)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (col == 4'(~(4'b0001 << c))) row = ~keys[c*4 +: 4];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int lowest(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] data_word(input int code);
    logic [3:0] c;
    c = code[3:0];
    return {23'd0, 1'b1, 4'd0, c};
  endfunction

  function automatic logic [31:0] status_word(input bit held);
    return {27'd0, held, exp_ovf, 3'(exp_q.size())};
  endfunction

  task automatic model_push(input int code);
    if (exp_q.size() < 4) exp_q.push_back(code);
    else exp_ovf = 1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic ahb_write(input logic [3:0] off, input logic [31:0] data);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = {28'd0, off};
    @(posedge HCLK); #1;
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [3:0] off, output logic [31:0] data);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = {28'd0, off};
    @(posedge HCLK); #1;
    HSEL = 0; HTRANS = 2'b00;
    data = HRDATA;
    @(posedge HCLK); #1;
  endtask

  // Returns just after the edge where the scan wraps from column 3 to column 0.
  task automatic align();
    logic [3:0] prev;
    bit ok;
    ok = 0;
    prev = col;
    for (int i = 0; i < 64; i++) begin
      @(posedge HCLK); #1;
      if (prev == 4'b0111 && col == 4'b1110) begin ok = 1; break; end
      prev = col;
    end
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL align: no frame wrap seen, col=%h", col); end
  endtask

  task automatic press_release(input logic [15:0] m);
    keys = m;
    tick(6 * FRAME);
    keys = 16'd0;
    tick(6 * FRAME);
    if (lowest(m) >= 0) model_push(lowest(m));
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    HRESETn = 0; keys = 0; HSEL = 0; HTRANS = 0; HWRITE = 0;
    HADDR = 0; HWDATA = 0; HREADY = 1;
    tick(3);
    n_checks++;
    if (col !== 4'hF || irq !== 1'b0 || HREADYOUT !== 1'b1 || HRDATA !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: col=%h irq=%b hreadyout=%b hrdata=%h, want F 0 1 0",
               col, irq, HREADYOUT, HRDATA);
    end
    HRESETn = 1;
    tick(1);
    ahb_write(4'hC, $urandom);
    for (int i = 0; i < 4; i++) begin
      ahb_read(4'(i * 4), rd);
      n_checks++;
      if (rd !== 32'd0) begin
        n_errors++; $display("FAIL reset_read_%0d: got %h want 0", i * 4, rd);
      end
    end
  endtask

  task automatic test_single_key();
    logic [31:0] rd;
    int exp;
    ahb_write(4'h8, 32'd3);
    ahb_read(4'h8, rd);
    n_checks++;
    if (rd !== 32'd3) begin n_errors++; $display("FAIL ctrl_read: got %h want 3", rd); end
    align();
    keys = 16'd1 << 6;
    tick(49);
    n_checks++;
    if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_early: got %b want 0", irq); end
    tick(1);
    model_push(6);
    n_checks++;
    if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_rise: got %b want 1", irq); end
    ahb_read(4'h4, rd);
    n_checks++;
    if (rd !== status_word(1)) begin
      n_errors++; $display("FAIL single_status: got %h want %h", rd, status_word(1));
    end
    ahb_read(4'h0, rd);
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== data_word(exp) || rd !== 32'h106) begin
      n_errors++; $display("FAIL single_data: got %h want %h", rd, data_word(exp));
    end
    n_checks++;
    if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_hold: got %b want 1", irq); end
    tick(1);
    n_checks++;
    if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_fall: got %b want 0", irq); end
    ahb_read(4'h0, rd);
    n_checks++;
    if (rd !== 32'd0) begin n_errors++; $display("FAIL empty_data: got %h want 0", rd); end
    keys = 16'd0;
    tick(6 * FRAME);
  endtask

  task automatic test_bounce();
    logic [31:0] rd;
    int k, lat, exp;
    k = $urandom_range(0, 15);
    for (int i = 0; i < 2 * $urandom_range(2, 4); i++) begin
      keys[k] = ~keys[k];
      tick(20);
    end
    tick(20);
    ahb_read(4'h4, rd);
    n_checks++;
    if (rd !== status_word(0) || irq !== 1'b0) begin
      n_errors++; $display("FAIL bounce_reject: status %h irq %b want %h 0", rd, irq, status_word(0));
    end
    align();
    keys[k] = 1'b1;
    lat = -1;
    for (int i = 1; i <= 80; i++) begin
      @(posedge HCLK); #1;
      if (irq === 1'b1) begin lat = i; break; end
    end
    model_push(k);
    n_checks++;
    if (lat < 0 || lat - 1 > 3 * FRAME + 3) begin
      n_errors++; $display("FAIL bounce_latency: push after %0d cycles, limit %0d", lat - 1, 3 * FRAME + 3);
    end
    tick(4 * FRAME);
    ahb_read(4'h4, rd);
    n_checks++;
    if (rd !== status_word(1)) begin
      n_errors++; $display("FAIL bounce_single_push: status %h want %h", rd, status_word(1));
    end
    ahb_read(4'h0, rd);
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== data_word(exp)) begin
      n_errors++; $display("FAIL bounce_code: got %h want %h", rd, data_word(exp));
    end
    keys = 16'd0;
    tick(6 * FRAME);
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    int codes[5] = '{0, 5, 10, 15, 3};
    int exp;
    foreach (codes[i]) press_release(16'd1 << codes[i]);
    ahb_read(4'h4, rd);
    n_checks++;
    if (rd !== status_word(0) || rd !== 32'h0C) begin
      n_errors++; $display("FAIL ovf_status: got %h want %h", rd, status_word(0));
    end
    for (int i = 0; i < 4; i++) begin
      ahb_read(4'h0, rd);
      exp = exp_q.pop_front();
      n_checks++;
      if (rd !== data_word(exp)) begin
        n_errors++; $display("FAIL ovf_data_%0d: got %h want %h", i, rd, data_word(exp));
      end
    end
    ahb_read(4'h4, rd);
    n_checks++;
    if (rd !== status_word(0)) begin
      n_errors++; $display("FAIL ovf_sticky: got %h want %h", rd, status_word(0));
    end
    ahb_write(4'h4, 32'h8 | ($urandom & ~32'h8));
    exp_ovf = 0;
    ahb_read(4'h4, rd);
    n_checks++;
    if (rd !== status_word(0)) begin
      n_errors++; $display("FAIL ovf_clear: got %h want %h", rd, status_word(0));
    end
  endtask

  task automatic test_multi_key();
    logic [31:0] rd;
    int a, b, exp;
    for (int r = 0; r < 3; r++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      press_release((16'd1 << a) | (16'd1 << b));
      ahb_read(4'h0, rd);
      exp = exp_q.pop_front();
      n_checks++;
      if (rd !== data_word(exp)) begin
        n_errors++; $display("FAIL multi_key_%0d: got %h want %h", r, rd, data_word(exp));
      end
    end
  endtask

  task automatic test_push_pop();
    logic [31:0] rd;
    int x, exp;
    for (int i = 0; i < 4; i++) press_release(16'd1 << $urandom_range(0, 15));
    align();
    x = $urandom_range(0, 15);
    keys = 16'd1 << x;
    tick(47);
    ahb_read(4'h0, rd);
    exp = exp_q.pop_front();
    model_push(x);
    n_checks++;
    if (rd !== data_word(exp)) begin
      n_errors++; $display("FAIL full_pp_data: got %h want %h", rd, data_word(exp));
    end
    ahb_read(4'h4, rd);
    n_checks++;
    if (rd !== status_word(1)) begin
      n_errors++; $display("FAIL full_pp_status: got %h want %h", rd, status_word(1));
    end
    keys = 16'd0;
    tick(6 * FRAME);
    for (int i = 0; i < 4; i++) begin
      ahb_read(4'h0, rd);
      exp = exp_q.pop_front();
      n_checks++;
      if (rd !== data_word(exp)) begin
        n_errors++; $display("FAIL full_pp_drain_%0d: got %h want %h", i, rd, data_word(exp));
      end
    end
    press_release(16'd1 << $urandom_range(0, 15));
    align();
    x = $urandom_range(0, 15);
    keys = 16'd1 << x;
    tick(47);
    ahb_read(4'h0, rd);
    exp = exp_q.pop_front();
    model_push(x);
    n_checks++;
    if (rd !== data_word(exp)) begin
      n_errors++; $display("FAIL one_pp_data: got %h want %h", rd, data_word(exp));
    end
    ahb_read(4'h4, rd);
    n_checks++;
    if (rd !== status_word(1)) begin
      n_errors++; $display("FAIL one_pp_status: got %h want %h", rd, status_word(1));
    end
    ahb_read(4'h0, rd);
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== data_word(exp)) begin
      n_errors++; $display("FAIL one_pp_tail: got %h want %h", rd, data_word(exp));
    end
    keys = 16'd0;
    tick(6 * FRAME);
  endtask

  task automatic test_disable_reset();
    logic [31:0] rd;
    logic [3:0]  ecol;
    press_release(16'd1 << $urandom_range(0, 15));
    press_release(16'd1 << $urandom_range(0, 15));
    n_checks++;
    if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_pending: got %b want 1", irq); end
    align();
    tick(7);
    ecol = 4'b0001 << (7 / 4);
    ecol = ~ecol;
    n_checks++;
    if (col !== ecol) begin n_errors++; $display("FAIL mid_frame_col: got %h want %h", col, ecol); end
    ahb_write(4'h8, 32'd2);
    n_checks++;
    if (col !== 4'hF) begin n_errors++; $display("FAIL disable_col: got %h want F", col); end
    ahb_read(4'h4, rd);
    n_checks++;
    if (rd !== status_word(0)) begin
      n_errors++; $display("FAIL disable_keeps_fifo: got %h want %h", rd, status_word(0));
    end
    ahb_write(4'h8, 32'd3);
    tick(21);
    #2 HRESETn = 0;
    #1;
    exp_q.delete();
    exp_ovf = 0;
    n_checks++;
    if (col !== 4'hF || irq !== 1'b0 || HRDATA !== 32'd0) begin
      n_errors++; $display("FAIL async_reset: col=%h irq=%b hrdata=%h want F 0 0", col, irq, HRDATA);
    end
    @(negedge HCLK) HRESETn = 1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      ahb_read(4'(i * 4), rd);
      n_checks++;
      if (rd !== 32'd0) begin
        n_errors++; $display("FAIL post_reset_read_%0d: got %h want 0", i * 4, rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_overflow();
    test_multi_key();
    test_push_pop();
    test_disable_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
